// File: rtl/int_to_fp_seq.sv
// Iterative signed-integer to IEEE-754 single converter; one normalize shift per cycle, then round, then hold.
// Latency: accept edge to vld_o is sh+2 cycles (2..INT_W+1). Rounding mode set by INT2FP_ROUND_EN (RNE) else truncate.
// Backpressure: rdy_o only in IDLE; result held stable in HOLD until rdy_i, one conversion in flight.

package float_types_pkg;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_point_num;
endpackage

module int_to_fp_seq
    import float_types_pkg::*;
#(
    parameter int INT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [INT_W-1:0] int_i,
    input  logic             vld_i,
    output logic             rdy_o,
    output float_point_num   result_o,
    output logic             zero_o,
    output logic             inexact_o,
    output logic             vld_o,
    input  logic             rdy_i
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, HOLD} state_t;

    state_t         state_q, state_d;
    logic           sign_q;
    logic [INT_W-1:0] mag_q;
    logic [INT_W-1:0] mag_in;
    logic [4:0]     sh_q;
    float_point_num result_q, res_d;
    logic           zero_q, inexact_q;

    logic           mag_zero;
    logic [30:0]    frac_al;
    logic [22:0]    mant;
    logic           guard_bit, sticky_bit, inc;
    logic [23:0]    mant_sum;
    logic [7:0]     exp_base, exp_fin;

    // Two's-complement magnitude; the most negative value maps to 2^(INT_W-1) unsigned.
    assign mag_in   = int_i[INT_W-1] ? ('0 - int_i) : int_i;
    assign mag_zero = (mag_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vld_i) state_d = NORM;
            NORM:    if (mag_zero || mag_q[INT_W-1]) state_d = ROUND;
            ROUND:   state_d = HOLD;
            HOLD:    if (rdy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fraction bits below the hidden one, left-aligned so bit 30 is the first mantissa bit.
    always_comb begin
        frac_al    = 31'(mag_q[INT_W-2:0]) << (32 - INT_W);
        mant       = frac_al[30:8];
        guard_bit  = frac_al[7];
        sticky_bit = |frac_al[6:0];
`ifdef INT2FP_ROUND_EN
        inc        = guard_bit & (sticky_bit | mant[0]);
`else
        inc        = 1'b0;
`endif
        mant_sum   = {1'b0, mant} + {23'd0, inc};
        exp_base   = 8'(127 + INT_W - 1) - {3'b000, sh_q};
        exp_fin    = exp_base + {7'd0, mant_sum[23]};
        res_d.sign = sign_q;
        res_d.exp  = exp_fin;
        res_d.mant = mant_sum[23] ? 23'd0 : mant_sum[22:0];
        if (mag_zero) res_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sign_q    <= 1'b0;
            mag_q     <= '0;
            sh_q      <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vld_i) begin
                        sign_q <= int_i[INT_W-1];
                        mag_q  <= mag_in;
                        sh_q   <= '0;
                    end
                end
                NORM: begin
                    if (!mag_zero && !mag_q[INT_W-1]) begin
                        mag_q <= mag_q << 1;
                        sh_q  <= sh_q + 5'd1;
                    end
                end
                ROUND: begin
                    result_q  <= res_d;
                    zero_q    <= mag_zero;
                    inexact_q <= mag_zero ? 1'b0 : (guard_bit | sticky_bit);
                end
                default: ;
            endcase
        end
    end

    // rdy_o is low for the whole reset assertion even though the state register already reads IDLE.
    assign rdy_o     = rst_ni & (state_q == IDLE);
    assign vld_o     = (state_q == HOLD);
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign inexact_o = inexact_q;

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Randomized and directed checks of int_to_fp_seq (INT_W=32) against an arithmetic reference model.
module tb_int_to_fp_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] int_v;
    logic        vld_in, rdy_out, vld_out, rdy_in;
    logic [31:0] res;
    logic        zero, inex;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    int_to_fp_seq #(.INT_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .int_i(int_v), .vld_i(vld_in), .rdy_o(rdy_out),
        .result_o(res), .zero_o(zero), .inexact_o(inex), .vld_o(vld_out), .rdy_i(rdy_in)
    );

    // Reference: locate leading one, divide down, round half-to-even on the remainder.
    function automatic void ref_conv(input logic [31:0] v, output logic [31:0] f,
                                     output logic z, output logic ix, output int lat);
        longint mag, mant, rem, half;
        int p, e, drop;
        logic s;
        s   = v[31];
        mag = s ? (64'h1_0000_0000 - longint'(v)) : longint'(v);
        if (mag == 0) begin
            f = 32'h0; z = 1'b1; ix = 1'b0; lat = 2;
            return;
        end
        p = 0;
        for (int i = 0; i < 32; i++) if (((mag >> i) & 1) != 0) p = i;
        lat = (31 - p) + 2;
        e   = 127 + p;
        z   = 1'b0;
        if (p <= 23) begin
            mant = (mag - (64'd1 << p)) << (23 - p);
            ix   = 1'b0;
        end else begin
            drop = p - 23;
            mant = (mag >> drop) & 64'h7F_FFFF;
            rem  = mag & ((64'd1 << drop) - 1);
            half = 64'd1 << (drop - 1);
            ix   = (rem != 0);
`ifdef INT2FP_ROUND_EN
            if (rem > half || (rem == half && (mant & 1) != 0)) mant = mant + 1;
            if (mant == 64'h80_0000) begin
                mant = 0;
                e    = e + 1;
            end
`endif
        end
        f = {s, 8'(e), 23'(mant)};
    endfunction

    task automatic run_conv(input logic [31:0] v, input bit early_rdy, output logic [31:0] r,
                            output logic z, output logic ix, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (rdy_out !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        int_v  = v;
        vld_in = 1'b1;
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        int_v  = $urandom;
        if (early_rdy) rdy_in = 1'b1;
        lat = 0;
        while (vld_out !== 1'b1 && lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
        end
        r  = res;
        z  = zero;
        ix = inex;
        rdy_in = 1'b1;
        @(posedge clk);
        #1;
        rdy_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vld_in = 1'b0; rdy_in = 1'b0; int_v = '0;
        #12;
        n_cmp++; if (rdy_out !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b want 0", rdy_out); end
        n_cmp++; if (vld_out !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", vld_out); end
        n_cmp++; if (res !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", res); end
        n_cmp++; if ({zero, inex} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {zero, inex}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (rdy_out !== 1'b1) begin n_err++; $display("FAIL idle_rdy: got %b want 1", rdy_out); end
    endtask

    task automatic test_directed();
        logic [31:0] vecs [6];
        logic [31:0] want [6];
        logic [31:0] r, ef;
        logic z, ix, ez, eix;
        int lat, elat;
        vecs = '{32'h1, 32'h8000_0000, 32'hFFFF_FFFD, 32'h0100_0003, 32'h7FFF_FFFF, 32'h0};
`ifdef INT2FP_ROUND_EN
        want = '{32'h3F80_0000, 32'hCF00_0000, 32'hC040_0000, 32'h4B80_0002, 32'h4F00_0000, 32'h0};
`else
        want = '{32'h3F80_0000, 32'hCF00_0000, 32'hC040_0000, 32'h4B80_0001, 32'h4EFF_FFFF, 32'h0};
`endif
        for (int i = 0; i < 6; i++) begin
            run_conv(vecs[i], 1'b0, r, z, ix, lat);
            ref_conv(vecs[i], ef, ez, eix, elat);
            n_cmp++; if (r !== want[i]) begin n_err++; $display("FAIL dir_result[%h]: got %h want %h", vecs[i], r, want[i]); end
            n_cmp++; if (z !== ez) begin n_err++; $display("FAIL dir_zero[%h]: got %b want %b", vecs[i], z, ez); end
            n_cmp++; if (ix !== eix) begin n_err++; $display("FAIL dir_inexact[%h]: got %b want %b", vecs[i], ix, eix); end
            n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL dir_latency[%h]: got %0d want %0d", vecs[i], lat, elat); end
        end
    endtask

    task automatic test_random();
        logic [31:0] v, r, ef;
        logic z, ix, ez, eix;
        int lat, elat;
        for (int i = 0; i < 40; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
            run_conv(v, ($urandom_range(0, 3) == 0), r, z, ix, lat);
            ref_conv(v, ef, ez, eix, elat);
            n_cmp++; if (r !== ef) begin n_err++; $display("FAIL rnd_result[%h]: got %h want %h", v, r, ef); end
            n_cmp++; if ({z, ix} !== {ez, eix}) begin n_err++; $display("FAIL rnd_flags[%h]: got %b want %b", v, {z, ix}, {ez, eix}); end
            n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL rnd_latency[%h]: got %0d want %0d", v, lat, elat); end
        end
    endtask

    task automatic test_back_to_back_backpressure();
        logic [31:0] ef, r;
        logic ez, eix, z, ix;
        int elat, guard, lat;
        ref_conv(32'h1234_5678, ef, ez, eix, elat);
        @(negedge clk);
        int_v = 32'h1234_5678; vld_in = 1'b1;
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        guard = 0;
        while (vld_out !== 1'b1 && guard < 60) begin @(posedge clk); guard++; #1; end
        n_cmp++; if (vld_out !== 1'b1) begin n_err++; $display("FAIL bp_wait: vld_o got %b want 1", vld_out); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++; if (res !== ef || rdy_out !== 1'b0 || vld_out !== 1'b1) begin
                n_err++; $display("FAIL bp_hold[%0d]: got res=%h rdy=%b vld=%b want res=%h rdy=0 vld=1", c, res, rdy_out, vld_out, ef);
            end
            int_v = $urandom; vld_in = (c % 2 == 0);
        end
        @(negedge clk);
        vld_in = 1'b0; rdy_in = 1'b1;
        @(posedge clk);
        #1;
        rdy_in = 1'b0;
        n_cmp++; if (vld_out !== 1'b0 || rdy_out !== 1'b1) begin n_err++; $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", vld_out, rdy_out); end
        n_cmp++; if (res !== ef) begin n_err++; $display("FAIL bp_stable_idle: got %h want %h", res, ef); end
        run_conv(32'hFFFF_FF00, 1'b0, r, z, ix, lat);
        ref_conv(32'hFFFF_FF00, ef, ez, eix, elat);
        n_cmp++; if (r !== ef || lat !== elat) begin n_err++; $display("FAIL bp_next: got %h/%0d want %h/%0d", r, lat, ef, elat); end
    endtask

    task automatic test_reset_mid();
        bit saw_vld;
        @(negedge clk);
        int_v = 32'h1; vld_in = 1'b1;
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (res !== 32'h0 || zero !== 1'b0 || inex !== 1'b0) begin n_err++; $display("FAIL midrst_outputs: got %h %b %b want 0 0 0", res, zero, inex); end
        n_cmp++; if (vld_out !== 1'b0 || rdy_out !== 1'b0) begin n_err++; $display("FAIL midrst_hs: got vld=%b rdy=%b want 0 0", vld_out, rdy_out); end
        @(negedge clk);
        rst_n = 1'b1;
        saw_vld = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (vld_out === 1'b1) saw_vld = 1'b1;
        end
        n_cmp++; if (saw_vld !== 1'b0) begin n_err++; $display("FAIL midrst_no_result: vld_o got 1 want 0"); end
        n_cmp++; if (rdy_out !== 1'b1) begin n_err++; $display("FAIL midrst_idle: rdy_o got %b want 1", rdy_out); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back_backpressure();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
